// File: rtl/fir_transient_sequencer.sv
// Transient characterisation sequencer for a FIR filter: warm-up, impulse,
// impulse-response capture, then a held step with settle/timeout measurement.
module fir_transient_sequencer #(
  parameter int DATA_WIDTH      = 16,
  parameter int OUT_WIDTH       = 32,
  parameter int AMPLITUDE       = 32767,
  parameter int WARMUP          = 10,
  parameter int IMPULSE_LEN     = 1,
  parameter int IMPULSE_CAPTURE = 200,
  parameter int STEP_CAPTURE    = 400,
  parameter int SETTLE_WIN      = 8,
  parameter int TOL             = 1024,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  output logic signed [DATA_WIDTH-1:0] fir_data_in,
  input  logic signed [OUT_WIDTH-1:0]  fir_data_out,
  output logic                         busy,
  output logic                         resp_valid,
  output logic                         resp_phase,
  output logic                         done,
  output logic                         timeout,
  output logic [OUT_WIDTH-1:0]         impulse_peak,
  output logic signed [OUT_WIDTH-1:0]  step_final,
  output logic [CNT_WIDTH-1:0]         settle_cycles
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WARMUP   = 3'd1;
  localparam logic [2:0] S_IMPULSE  = 3'd2;
  localparam logic [2:0] S_IMP_CAP  = 3'd3;
  localparam logic [2:0] S_STEP_CAP = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam logic [CNT_WIDTH-1:0] WARMUP_LAST = CNT_WIDTH'(WARMUP - 1);
  localparam logic [CNT_WIDTH-1:0] IMP_LAST    = CNT_WIDTH'(IMPULSE_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] ICAP_LAST   = CNT_WIDTH'(IMPULSE_CAPTURE - 1);
  localparam logic [CNT_WIDTH-1:0] SCAP_LAST   = CNT_WIDTH'(STEP_CAPTURE - 1);
  localparam logic [CNT_WIDTH-1:0] SCAP_LIMIT  = CNT_WIDTH'(STEP_CAPTURE);
  localparam logic [CNT_WIDTH-1:0] SETTLE_N    = CNT_WIDTH'(SETTLE_WIN);
  localparam logic [CNT_WIDTH-1:0] SETTLE_OFS  = CNT_WIDTH'(SETTLE_WIN - 1);
  localparam logic [OUT_WIDTH:0]   TOL_W       = (OUT_WIDTH+1)'(TOL);
  localparam logic signed [DATA_WIDTH-1:0] AMP = DATA_WIDTH'(AMPLITUDE);
  localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};

  logic [2:0]                  state_q, state_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]        stable_q, stable_d;
  logic signed [OUT_WIDTH-1:0] prev_q, prev_d;
  logic signed [DATA_WIDTH-1:0] fir_data_in_q, fir_data_in_d;
  logic [OUT_WIDTH-1:0]        impulse_peak_q, impulse_peak_d;
  logic signed [OUT_WIDTH-1:0] step_final_q, step_final_d;
  logic [CNT_WIDTH-1:0]        settle_cycles_q, settle_cycles_d;
  logic                        timeout_q, timeout_d;

  logic signed [OUT_WIDTH-1:0] y_neg;
  logic [OUT_WIDTH-1:0]        y_abs;
  logic signed [OUT_WIDTH:0]   diff;
  logic [OUT_WIDTH:0]          diff_abs;
  logic                        stable_ok;

  // Magnitude with the most-negative sample clamped to full scale.
  assign y_neg = -fir_data_out;
  always_comb begin
    if (!fir_data_out[OUT_WIDTH-1]) y_abs = fir_data_out;
    else if (fir_data_out == OUT_MIN) y_abs = OUT_MAX;
    else y_abs = y_neg;
  end

  // One extra bit keeps the sample-to-sample difference from wrapping.
  assign diff      = {fir_data_out[OUT_WIDTH-1], fir_data_out} - {prev_q[OUT_WIDTH-1], prev_q};
  assign diff_abs  = diff[OUT_WIDTH] ? -diff : diff;
  assign stable_ok = (diff_abs <= TOL_W);

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q + CNT_WIDTH'(1);
    stable_d        = stable_q;
    prev_d          = prev_q;
    impulse_peak_d  = impulse_peak_q;
    step_final_d    = step_final_q;
    settle_cycles_d = settle_cycles_q;
    timeout_d       = timeout_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start && !abort) begin
          state_d         = S_WARMUP;
          stable_d        = '0;
          impulse_peak_d  = '0;
          step_final_d    = '0;
          settle_cycles_d = '0;
          timeout_d       = 1'b0;
        end
      end
      S_WARMUP: begin
        if (cnt_q == WARMUP_LAST) begin
          state_d = S_IMPULSE;
          cnt_d   = '0;
        end
      end
      S_IMPULSE: begin
        if (cnt_q == IMP_LAST) begin
          state_d = S_IMP_CAP;
          cnt_d   = '0;
        end
      end
      S_IMP_CAP: begin
        if (y_abs > impulse_peak_q) impulse_peak_d = y_abs;
        prev_d = fir_data_out;
        if (cnt_q == ICAP_LAST) begin
          state_d = S_STEP_CAP;
          cnt_d   = '0;
        end
      end
      S_STEP_CAP: begin
        stable_d     = stable_ok ? stable_q + CNT_WIDTH'(1) : '0;
        prev_d       = fir_data_out;
        step_final_d = fir_data_out;
        if (stable_d == SETTLE_N) begin
          settle_cycles_d = cnt_q - SETTLE_OFS;
          state_d         = S_DONE;
          cnt_d           = '0;
        end else if (cnt_q == SCAP_LAST) begin
          timeout_d       = 1'b1;
          settle_cycles_d = SCAP_LIMIT;
          state_d         = S_DONE;
          cnt_d           = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end

    // Stimulus is registered alongside the state so it lines up with it.
    fir_data_in_d = ((state_d == S_IMPULSE) || (state_d == S_STEP_CAP)) ? AMP : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      stable_q        <= '0;
      prev_q          <= '0;
      fir_data_in_q   <= '0;
      impulse_peak_q  <= '0;
      step_final_q    <= '0;
      settle_cycles_q <= '0;
      timeout_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      stable_q        <= stable_d;
      prev_q          <= prev_d;
      fir_data_in_q   <= fir_data_in_d;
      impulse_peak_q  <= impulse_peak_d;
      step_final_q    <= step_final_d;
      settle_cycles_q <= settle_cycles_d;
      timeout_q       <= timeout_d;
    end
  end

  assign fir_data_in   = fir_data_in_q;
  assign busy          = (state_q != S_IDLE);
  assign resp_valid    = (state_q == S_IMP_CAP) || (state_q == S_STEP_CAP);
  assign resp_phase    = (state_q == S_STEP_CAP);
  assign done          = (state_q == S_DONE);
  assign timeout       = timeout_q;
  assign impulse_peak  = impulse_peak_q;
  assign step_final    = step_final_q;
  assign settle_cycles = settle_cycles_q;

endmodule

// File: tb/tb_fir_transient_sequencer.sv
// Bench for fir_transient_sequencer: stub filters driven from the DUT stimulus,
// a schedule/result model built from the run rules, and per-cycle comparison.
module tb_fir_transient_sequencer;

  localparam int W    = 10;
  localparam int L    = 1;
  localparam int IC   = 200;
  localparam int SC   = 400;
  localparam int SW   = 8;
  localparam int TOLV = 1024;
  localparam longint AMP = 32767;
  localparam int NK   = 1024;

  logic clk = 1'b0;
  logic rst_n, start, abort;
  logic signed [15:0] fir_data_in;
  logic signed [31:0] fir_data_out;
  logic busy, resp_valid, resp_phase, done, timeout;
  logic [31:0] impulse_peak;
  logic signed [31:0] step_final;
  logic [15:0] settle_cycles;

  fir_transient_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .fir_data_in(fir_data_in), .fir_data_out(fir_data_out),
    .busy(busy), .resp_valid(resp_valid), .resp_phase(resp_phase),
    .done(done), .timeout(timeout), .impulse_peak(impulse_peak),
    .step_final(step_final), .settle_cycles(settle_cycles)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Stub filter: 0 = silent, 1 = one-cycle register, 2 = 4-tap moving sum,
  // plus a per-run-cycle additive term and an optional most-negative override.
  int     filt_mode;
  longint hist [4];
  longint add_a [NK];
  bit     ovr_en [NK];

  // Model results
  longint m_y [NK];
  longint m_peak, m_final;
  int     m_settle, m_timeout, m_end, m_ss;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_pert();
    for (int i = 0; i < NK; i++) begin
      add_a[i]  = 0;
      ovr_en[i] = 1'b0;
    end
  endtask

  task automatic stub_update(input int k);
    longint f;
    f = 0;
    if (filt_mode == 1) f = hist[0];
    if (filt_mode == 2) f = hist[0] + hist[1] + hist[2] + hist[3];
    if (k >= 0 && k < NK) begin
      if (ovr_en[k]) f = -64'sd2147483648;
      else f = f + add_a[k];
    end
    fir_data_out = 32'(f);
    hist[3] = hist[2];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = longint'(fir_data_in);
  endtask

  function automatic longint xm(input int k);
    if (k >= W && k < W + L) return AMP;
    if (k >= W + L + IC && k < W + L + IC + SC) return AMP;
    return 0;
  endfunction

  function automatic longint sat_abs(input longint v);
    longint a;
    a = (v < 0) ? -v : v;
    if (a > 64'sd2147483647) a = 64'sd2147483647;
    return a;
  endfunction

  // Results from the rules: peak magnitude over the capture window, then the
  // first SETTLE_WIN-long run of small step differences, else the limit.
  task automatic build_model();
    int nend;
    bit ok;
    longint d;
    m_ss = W + L + IC;
    for (int k = 0; k < NK; k++) begin
      longint f;
      f = 0;
      if (filt_mode == 1) f = xm(k - 1);
      if (filt_mode == 2) f = xm(k - 1) + xm(k - 2) + xm(k - 3) + xm(k - 4);
      m_y[k] = ovr_en[k] ? -64'sd2147483648 : f + add_a[k];
    end
    m_peak = 0;
    for (int k = W + L; k < m_ss; k++)
      if (sat_abs(m_y[k]) > m_peak) m_peak = sat_abs(m_y[k]);
    nend = -1;
    for (int n = SW - 1; n < SC && nend < 0; n++) begin
      ok = 1'b1;
      for (int j = n - SW + 1; j <= n; j++) begin
        d = m_y[m_ss + j] - m_y[m_ss + j - 1];
        if (d < 0) d = -d;
        if (d > TOLV) ok = 1'b0;
      end
      if (ok) nend = n;
    end
    if (nend >= 0) begin
      m_settle  = nend - SW + 1;
      m_timeout = 0;
    end else begin
      nend      = SC - 1;
      m_settle  = SC;
      m_timeout = 1;
    end
    m_final = m_y[m_ss + nend];
    m_end   = m_ss + nend + 1;
  endtask

  task automatic run_seq(input int mode, input int abort_in, input bit busy_starts,
                         input int reset_at, input string tag);
    int abort_at, last, first_amp, done_k, ndone;
    bit eb, erv, erp, ed;
    longint ex;
    filt_mode = mode;
    build_model();
    abort_at = abort_in;
    if (abort_at == -2)
      abort_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, m_end - 1)) : -1;
    last = (abort_at >= 0) ? abort_at : m_end;
    first_amp = -1; done_k = -1; ndone = 0;

    @(negedge clk);
    stub_update(-1);
    chk("idle_busy", busy, 0);
    start = 1'b1;
    abort = 1'b0;

    for (int k = 0; k <= last + 6; k++) begin
      @(negedge clk);
      stub_update(k);
      start = 1'b0;
      abort = 1'b0;
      eb = 0; erv = 0; erp = 0; ed = 0; ex = 0;
      if ((abort_at >= 0 && k > abort_at) || k > m_end) begin
        eb = 0;
      end else if (k == m_end) begin
        eb = 1; ed = 1;
      end else if (k < W) begin
        eb = 1;
      end else if (k < W + L) begin
        eb = 1; ex = AMP;
      end else if (k < m_ss) begin
        eb = 1; erv = 1;
      end else begin
        eb = 1; erv = 1; erp = 1; ex = AMP;
      end
      chk($sformatf("%s busy@%0d", tag, k), busy, eb);
      chk($sformatf("%s resp_valid@%0d", tag, k), resp_valid, erv);
      chk($sformatf("%s resp_phase@%0d", tag, k), resp_phase, erp);
      chk($sformatf("%s done@%0d", tag, k), done, ed);
      chk($sformatf("%s fir_data_in@%0d", tag, k), longint'(fir_data_in), ex);
      if (done) begin ndone++; done_k = k; end
      if (fir_data_in == 16'sd32767 && first_amp < 0) first_amp = k;
      if (abort_at < 0 && (k == m_end || k == m_end + 5)) begin
        chk($sformatf("%s impulse_peak@%0d", tag, k), longint'(impulse_peak), m_peak);
        chk($sformatf("%s step_final@%0d", tag, k), longint'(step_final), m_final);
        chk($sformatf("%s settle_cycles@%0d", tag, k), longint'(settle_cycles), m_settle);
        chk($sformatf("%s timeout@%0d", tag, k), timeout, m_timeout);
      end
      if (abort_at >= 0 && abort_at < m_ss && k == abort_at + 3) begin
        chk($sformatf("%s partial_final", tag), longint'(step_final), 0);
        chk($sformatf("%s partial_settle", tag), longint'(settle_cycles), 0);
        chk($sformatf("%s partial_timeout", tag), timeout, 0);
      end
      if (k == reset_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst busy", busy, 0);
        chk("rst resp_valid", resp_valid, 0);
        chk("rst resp_phase", resp_phase, 0);
        chk("rst done", done, 0);
        chk("rst fir_data_in", longint'(fir_data_in), 0);
        chk("rst impulse_peak", longint'(impulse_peak), 0);
        chk("rst step_final", longint'(step_final), 0);
        chk("rst settle_cycles", longint'(settle_cycles), 0);
        chk("rst timeout", timeout, 0);
        repeat (3) begin
          @(negedge clk);
          stub_update(-1);
        end
        rst_n = 1'b1;
        repeat (5) begin
          @(negedge clk);
          stub_update(-1);
          chk("post_rst busy", busy, 0);
        end
        $display("run %s mode=%0d reset at k=%0d", tag, mode, k);
        return;
      end
      if (k == abort_at) abort = 1'b1;
      if (busy_starts && k <= last && $urandom_range(0, 15) == 0) start = 1'b1;
    end

    if (abort_at < 0) begin
      chk($sformatf("%s done_count", tag), ndone, 1);
      chk($sformatf("%s run_length", tag), done_k - first_amp + 1, m_end - W + 1);
    end else begin
      chk($sformatf("%s done_count", tag), ndone, 0);
    end
    $display("run %s mode=%0d abort=%0d peak=%0d final=%0d settle=%0d timeout=%0d",
             tag, mode, abort_at, impulse_peak, step_final, settle_cycles, timeout);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; fir_data_out = '0;
    for (int i = 0; i < 4; i++) hist[i] = 0;
    filt_mode = 1;
    clear_pert();
    repeat (2) begin
      @(negedge clk);
      stub_update(-1);
    end
    chk("reset busy", busy, 0);
    chk("reset fir_data_in", longint'(fir_data_in), 0);
    chk("reset impulse_peak", longint'(impulse_peak), 0);
    chk("reset settle_cycles", longint'(settle_cycles), 0);
    rst_n = 1'b1;

    // abort together with start in IDLE: nothing happens
    @(negedge clk); stub_update(-1);
    start = 1'b1; abort = 1'b1;
    @(negedge clk); stub_update(-1);
    start = 1'b0; abort = 1'b0;
    chk("start_abort busy", busy, 0);

    // Register stub
    filt_mode = 1; build_model();
    chk("pin reg peak", m_peak, 32767);
    chk("pin reg final", m_final, 32767);
    chk("pin reg settle", m_settle, 2);
    chk("pin reg timeout", m_timeout, 0);
    chk("pin reg length", m_end - W + 1, 212);
    run_seq(1, -1, 1'b0, -1, "reg");

    // 4-tap moving sum stub
    filt_mode = 2; build_model();
    chk("pin sum4 peak", m_peak, 32767);
    chk("pin sum4 final", m_final, 131068);
    chk("pin sum4 settle", m_settle, 5);
    run_seq(2, -1, 1'b0, -1, "sum4");

    // Alternating +/-5000 during step: never settles
    clear_pert();
    for (int n = 0; n < SC; n++) add_a[W + L + IC + n] = (n % 2 == 0) ? 5000 : -5000;
    filt_mode = 0; build_model();
    chk("pin alt timeout", m_timeout, 1);
    chk("pin alt settle", m_settle, 400);
    chk("pin alt step_len", m_end - m_ss, 400);
    run_seq(0, -1, 1'b0, -1, "alt");
    clear_pert();

    // Abort on the 50th capture cycle, then a clean rerun
    run_seq(1, W + L + 49, 1'b0, -1, "abort");
    run_seq(1, -1, 1'b0, -1, "rerun");
    chk("rerun peak", longint'(impulse_peak), 32767);
    chk("rerun final", longint'(step_final), 32767);
    chk("rerun settle", longint'(settle_cycles), 2);

    // Most-negative sample in capture, starts pulsed while busy
    ovr_en[W + L + 30] = 1'b1;
    filt_mode = 1; build_model();
    chk("pin min peak", m_peak, 64'sd2147483647);
    run_seq(1, -1, 1'b1, -1, "minval");
    clear_pert();

    // Reset in the middle of the step, then a normal run
    run_seq(1, -1, 1'b0, W + L + IC + 3, "reset");
    run_seq(1, -1, 1'b0, -1, "after_reset");

    // Randomised runs
    for (int r = 0; r < 10; r++) begin
      int amp_n;
      clear_pert();
      amp_n = (r % 3) * 300;
      for (int k = 0; k < NK; k++)
        add_a[k] = longint'(int'($urandom_range(0, 2 * amp_n)) - amp_n);
      if ($urandom_range(0, 3) == 0) ovr_en[W + L + int'($urandom_range(0, IC - 1))] = 1'b1;
      run_seq(int'($urandom_range(1, 2)), -2, 1'b1, -1, $sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fir_transient_sequencer.md
Name: fir_transient_sequencer

Overview:
Self-contained controller that sequences the 100-tap fir_filter through a transient characterisation run: warm-up zeros, an impulse, an impulse-response capture window, then a held step. It measures the impulse-response peak, the step final value and the step settling time. It sits between a host or bench control interface and the filter's data_in/data_out, replacing free-running stimulus with a deterministic, restartable schedule.

Parameters:
DATA_WIDTH, 16, width of fir_data_in
OUT_WIDTH, 32, width of fir_data_out and the result registers
AMPLITUDE, 32767, signed impulse/step level
WARMUP, 10, zero-input cycles before the impulse
IMPULSE_LEN, 1, cycles AMPLITUDE is held for the impulse
IMPULSE_CAPTURE, 200, zero-input capture cycles after the impulse (≥ filter taps)
STEP_CAPTURE, 400, maximum step capture cycles before timeout
SETTLE_WIN, 8, consecutive stable samples required to declare settled
TOL, 1024, maximum |y[n]-y[n-1]| counted as stable
CNT_WIDTH, 16, width of cycle counters and settle_cycles

Ports:
clk  in  1  system clock, one sample per cycle
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle run request
abort  in  1  cancel the run in progress
fir_data_in  out  DATA_WIDTH  registered stimulus to the filter (signed)
fir_data_out  in  OUT_WIDTH  filter response (signed)
busy  out  1  high in every state except IDLE
resp_valid  out  1  fir_data_out is being captured this cycle
resp_phase  out  1  0 = impulse capture, 1 = step capture
done  out  1  one-cycle pulse at run completion
timeout  out  1  step did not settle within STEP_CAPTURE; held with results
impulse_peak  out  OUT_WIDTH  max |fir_data_out| seen during impulse capture
step_final  out  OUT_WIDTH  last step-capture sample (signed)
settle_cycles  out  CNT_WIDTH  step-capture index of the first sample of the settling window

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs and results 0; counters cleared.
- FSM states: IDLE, WARMUP, IMPULSE, IMP_CAP, STEP_CAP, DONE. One counter is reloaded on every state entry.
- IDLE: fir_data_in=0. If start=1 → WARMUP next cycle; results, timeout and the stable counter are cleared on that edge. start is ignored in all other states.
- WARMUP: fir_data_in=0 for exactly WARMUP cycles → IMPULSE.
- IMPULSE: fir_data_in=AMPLITUDE for exactly IMPULSE_LEN cycles → IMP_CAP.
- IMP_CAP: fir_data_in=0, resp_valid=1, resp_phase=0 for IMPULSE_CAPTURE cycles. Each cycle impulse_peak ← max(impulse_peak, |y|). |most-negative| saturates to the most-positive value. The last sample is loaded into prev on exit → STEP_CAP.
- STEP_CAP: fir_data_in=AMPLITUDE, resp_valid=1, resp_phase=1. n = cycle index starting at 0.
  - Each cycle: if |y-prev| ≤ TOL, stable++; otherwise stable=0. Then prev←y and step_final←y.
  - When stable reaches SETTLE_WIN at index n: settle_cycles = n-SETTLE_WIN+1 → DONE.
  - If n = STEP_CAPTURE-1 without settling: timeout=1, settle_cycles=STEP_CAPTURE → DONE. If settling and the limit occur in the same cycle, settled wins.
  - Difference arithmetic uses OUT_WIDTH+1 bits, so there is no wrap.
- DONE: fir_data_in=0, done=1 for one cycle → IDLE. Results hold until the next accepted start.
- abort=1 in any non-IDLE state → IDLE next cycle: fir_data_in=0, no done pulse, results left partial. abort has priority over all transitions. abort in IDLE has no effect.
- start and abort asserted together in IDLE: abort wins, no run.
- Run length, impulse to DONE: IMPULSE_LEN+IMPULSE_CAPTURE+(settle index+SETTLE_WIN)+1 cycles.

Test Plan:
- Reset mid-STEP_CAP (rst_n low 3 cycles) → all outputs 0 immediately (async), IDLE after release; a new start runs normally.
- Stub filter = one-cycle register of fir_data_in (sign-extended); start → busy rises next cycle, impulse_peak=32767, step_final=32767, settle_cycles=2, timeout=0, done pulses exactly 1 cycle.
- Stub = 4-tap moving sum (coeffs 1) → impulse_peak=32767, step_final=131068, step ramps over 4 samples, settle_cycles=5.
- Stub outputs alternating ±5000 during step → no settling; timeout=1, settle_cycles=400, done after 400 step cycles.
- abort on the 50th IMP_CAP cycle → IDLE next cycle, fir_data_in=0, no done; start again → full run, results identical to the uninterrupted run.
- Stub outputs -2^31 once in IMP_CAP → impulse_peak=2^31-1; start pulsed while busy → ignored, run length unchanged.
